seq_alu: RTL and testbench
==========================

# seq_alu

Registered, handshaked ALU parametrised in operand width, adding multi-cycle multiply, shifts and status flags to the combinational opsel ALU. It accepts one operation at a time over a valid/ready input channel and returns the result and flags over a valid/ready output channel. It sits between the datapath sequencer and the register-file write-back stage.

## Interface
- `WIDTH`, default 32: operand and result width. Must be a power of two and ≥ 4.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: operands and opcode are valid.
- `in_ready`  out  1: the block accepts the operation this cycle.
- `A`  in  WIDTH: first operand.
- `B`  in  WIDTH: second operand, or shift amount in its low `$clog2(WIDTH)` bits.
- `opsel`  in  4: opcode from `seq_alu_opsel.vh`.
- `out_valid`  out  1: `R` and the flags are valid.
- `out_ready`  in  1: the consumer takes the result this cycle.
- `R`  out  WIDTH: registered result.
- `flag_z`, `flag_n`, `flag_c`, `flag_v`  out  1 each: zero, negative (`R[WIDTH-1]`), carry, signed overflow.

## Operation
- **Opcodes:** NONE=0, AND=1, OR=2, XOR=3, NEG=4 (`~A`), ADD=5, SUB=6, MUL=7, SHL=8, SHR=9 (logical), SRA=10 (arithmetic).
- **Undefined opcodes (11–15)** execute as NONE.
- **NONE:** `R`=0, Z=1, other flags 0. Never X.
- **Handshake:** a transfer occurs on a rising edge where `valid && ready`.
- **`in_ready`:** combinational, `state==IDLE || (state==DONE && out_ready)`. This allows back-to-back issue with no bubble.
- **FSM states:**
  - IDLE → DONE on accepting a single-cycle op.
  - IDLE → MUL on accepting MUL.
  - MUL → DONE when the iteration counter reaches WIDTH.
  - DONE → IDLE on an output transfer with no new input.
  - DONE → DONE or MUL on simultaneous output and input transfers.
- **Width rules:**
  - ADD/SUB are computed at WIDTH+1 bits.
  - ADD: C = carry-out.
  - SUB: C = borrow, i.e. `A < B` unsigned.
  - V = signed overflow for ADD/SUB; 0 for all other ops.
- **Logic ops and NEG:** C=0, V=0.
- **Shifts:** amount `sh = B[$clog2(WIDTH)-1:0]`; upper bits of B are ignored. C = last bit shifted out, or 0 when `sh`=0.
- **MUL:** unsigned shift-add producing a 2·WIDTH-bit product, one B bit per cycle. `R` = low WIDTH bits. C = 1 iff the high half is non-zero.
- **Operand capture:** A, B and opsel are captured at acceptance. Later input changes do not affect an op in flight.
- **Result stability:** while `out_valid && !out_ready`, `R` and all flags hold stable and `in_ready`=0.
- **Reset:** abandons any operation in flight, including mid-MUL. The accepted op produces no output.

## Timing
- **Reset values:**
  - `out_valid`=0, `R`=0, all flags 0, state IDLE.
  - `in_ready`=1 while `rst_n` is low and immediately after its release.
- **Single-cycle op latency:** accepted on edge k → `out_valid`=1 from edge k+1.
- **MUL latency:** accepted on edge k → iterations on edges k+1…k+WIDTH → `out_valid`=1 from edge k+WIDTH. `in_ready`=0 throughout.
- **Throughput:** one single-cycle op per clock when `out_ready` is held high.
- **`out_valid`** falls on the edge after an output transfer unless a new op was accepted on the same edge.

## Structure
- `seq_alu_opsel.vh`: `OPSEL_*` 4-bit opcode defines and FSM state encodings (IDLE=0, MUL=1, DONE=2). Shared with the decoder.
- Sub-module `seq_alu_mul`: iterative multiplier with start/busy/done, parametrised by WIDTH. It holds the accumulator and counter.
- The top level holds the FSM, handshake logic, single-cycle datapath and output registers.

## Test plan
All scenarios use WIDTH=32.

1. ADD `A=0xFFFFFFFF`, `B=1` → `R=0`, Z=1, C=1, V=0, N=0; `out_valid` one cycle after acceptance.
2. SUB `A=0x80000000`, `B=1` → `R=0x7FFFFFFF`, V=1, C=0, N=0; then SUB `A=1`, `B=2` → `R=0xFFFFFFFF`, C=1, N=1.
3. MUL `A=0x00010000`, `B=0x00010000` → `R=0`, Z=1, C=1 exactly 32 cycles after acceptance; `in_ready`=0 for those cycles. Then MUL `7×6` → `R=42`, C=0.
4. SRA `A=0x80000000`, `B=0x24` (sh=4) → `R=0xF8000000`, N=1, C=0; SHL `A=0x80000001`, `B=1` → `R=2`, C=1.
5. Backpressure: ADD result with `out_ready`=0 for 5 cycles → `R` and flags stable, `in_ready`=0. With `out_ready`=1 and `in_valid`=1 on the same edge, the next result appears with no bubble.
6. Reset mid-MUL: assert `rst_n`=0 at cycle 10 of a MUL → `out_valid`=0, `R`=0, `in_ready`=1. A subsequent ADD `2+3` → `R=5`.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared opcode encodings, FSM states and flag bundle for seq_alu.
// Combinational helpers only; no state, no handshake.
package seq_alu_pkg;

  localparam logic [3:0] OPSEL_NONE = 4'd0;
  localparam logic [3:0] OPSEL_AND  = 4'd1;
  localparam logic [3:0] OPSEL_OR   = 4'd2;
  localparam logic [3:0] OPSEL_XOR  = 4'd3;
  localparam logic [3:0] OPSEL_NEG  = 4'd4;
  localparam logic [3:0] OPSEL_ADD  = 4'd5;
  localparam logic [3:0] OPSEL_SUB  = 4'd6;
  localparam logic [3:0] OPSEL_MUL  = 4'd7;
  localparam logic [3:0] OPSEL_SHL  = 4'd8;
  localparam logic [3:0] OPSEL_SHR  = 4'd9;
  localparam logic [3:0] OPSEL_SRA  = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

  // Codes above SRA are reserved and behave exactly like NONE.
  function automatic logic [3:0] legal_op(input logic [3:0] op);
    return (op > OPSEL_SRA) ? OPSEL_NONE : op;
  endfunction

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// Latency WIDTH cycles including the start cycle; no backpressure, start only when idle.
module seq_alu_mul #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, addend, acc_nxt;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    addend  = mplier_q[0] ? mcand_q : '0;
    acc_nxt = acc_q + addend;
  end

  // The start cycle already folds in partial product 0, so the counter
  // reaches WIDTH on the (WIDTH-1)th edge after start.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      acc_d    = b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand_d  = {{(WIDTH-1){1'b0}}, a, 1'b0};
      mplier_d = {1'b0, b[WIDTH-1:1]};
      cnt_d    = CW'(1);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = acc_nxt;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH-1)) begin
        busy_d = 1'b0;
      end
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CW'(WIDTH-1));
  assign prod = acc_nxt;

endmodule

// File: rtl/seq_alu.sv
// Registered valid/ready ALU with flags; MUL iterates in seq_alu_mul.
// Latency 1 cycle (MUL: WIDTH); result held and in_ready low while out_ready is low.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       opsel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] R,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int SW = $clog2(WIDTH);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     r_q, r_d;
  flags_t               flg_q, flg_d;

  logic [3:0]           op;
  logic                 op_mul, accept;
  logic                 mul_busy, mul_done;
  logic [2*WIDTH-1:0]   mul_prod;

  logic [SW-1:0]        sh;
  logic [WIDTH:0]       sum, diff, shl_x, shr_x, sra_x;
  logic [WIDTH-1:0]     alu_r;
  logic                 alu_c, alu_v;
  flags_t               alu_f;

  assign op     = legal_op(opsel);
  assign op_mul = (op == OPSEL_MUL);
  assign accept = in_valid && in_ready;

  seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept && op_mul),
    .a     (A),
    .b     (B),
    .busy  (mul_busy),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = op_mul ? ST_MUL : ST_DONE;
      ST_MUL: begin
        if (mul_done)       state_d = ST_DONE;
        else if (!mul_busy) state_d = ST_IDLE;
      end
      ST_DONE: begin
        if (accept)         state_d = op_mul ? ST_MUL : ST_DONE;
        else if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    out_valid = (state_q == ST_DONE);
  end

  // Shifts run one bit wider so the last bit shifted out lands in a fixed
  // position; with sh==0 that position holds the zero padding.
  always_comb begin
    sh    = B[SW-1:0];
    sum   = {1'b0, A} + {1'b0, B};
    diff  = {1'b0, A} - {1'b0, B};
    shl_x = {1'b0, A} << sh;
    shr_x = {A, 1'b0} >> sh;
    sra_x = $signed({A, 1'b0}) >>> sh;
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (op)
      OPSEL_AND: alu_r = A & B;
      OPSEL_OR:  alu_r = A | B;
      OPSEL_XOR: alu_r = A ^ B;
      OPSEL_NEG: alu_r = ~A;
      OPSEL_ADD: begin
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OPSEL_SUB: begin
        alu_r = diff[WIDTH-1:0];
        alu_c = diff[WIDTH];
        alu_v = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OPSEL_SHL: begin
        alu_r = shl_x[WIDTH-1:0];
        alu_c = shl_x[WIDTH];
      end
      OPSEL_SHR: begin
        alu_r = shr_x[WIDTH:1];
        alu_c = shr_x[0];
      end
      OPSEL_SRA: begin
        alu_r = sra_x[WIDTH:1];
        alu_c = sra_x[0];
      end
      default: alu_r = '0;
    endcase
    alu_f = '{z: (alu_r == '0), n: alu_r[WIDTH-1], c: alu_c, v: alu_v};
  end

  always_comb begin
    r_d   = r_q;
    flg_d = flg_q;
    if (accept && !op_mul) begin
      r_d   = alu_r;
      flg_d = alu_f;
    end else if ((state_q == ST_MUL) && mul_done) begin
      r_d   = mul_prod[WIDTH-1:0];
      flg_d = '{z: (mul_prod[WIDTH-1:0] == '0), n: mul_prod[WIDTH-1],
                c: |mul_prod[2*WIDTH-1:WIDTH], v: 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      flg_q <= '0;
    end else begin
      r_q   <= r_d;
      flg_q <= flg_d;
    end
  end

  assign R      = r_q;
  assign flag_z = flg_q.z;
  assign flag_n = flg_q.n;
  assign flag_c = flg_q.c;
  assign flag_v = flg_q.v;

endmodule

// File: tb/tb_seq_alu.sv
// Directed plus random stimulus for seq_alu (WIDTH=32) against an arithmetic reference model.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [3:0]  opsel = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] R;
  logic        flag_z, flag_n, flag_c, flag_v;

  int n_cmp = 0;
  int n_err = 0;

  seq_alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .opsel     (opsel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .R         (R),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_c    (flag_c),
    .flag_v    (flag_v)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] obs_pack();
    return {R, flag_z, flag_n, flag_c, flag_v};
  endfunction

  // Reference: {R, Z, N, C, V} from plain 64-bit integer arithmetic.
  function automatic logic [35:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0]     r;
    logic            c, v;
    longint unsigned p;
    longint          s;
    int              sh;
    sh = int'(b % 32);
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd1: r = a & b;
      4'd2: r = a | b;
      4'd3: r = a ^ b;
      4'd4: r = ~a;
      4'd5: begin
        p = longint'(a) + longint'(b);
        r = p[31:0];
        c = (p >= 64'h1_0000_0000);
        s = longint'($signed(a)) + longint'($signed(b));
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd6: begin
        r = a - b;
        c = (a < b);
        s = longint'($signed(a)) - longint'($signed(b));
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd7: begin
        p = longint'(a) * longint'(b);
        r = p[31:0];
        c = ((p >> 32) != 0);
      end
      4'd8: begin
        r = a << sh;
        c = (sh != 0) && (((a >> (32 - sh)) & 32'd1) != 0);
      end
      4'd9: begin
        r = a >> sh;
        c = (sh != 0) && (((a >> (sh - 1)) & 32'd1) != 0);
      end
      4'd10: begin
        r = $signed(a) >>> sh;
        c = (sh != 0) && (((a >> (sh - 1)) & 32'd1) != 0);
      end
      default: r = '0;
    endcase
    return {r, (r == 32'd0), r[31], c, v};
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    int lat, early, guard;
    @(negedge clk);
    in_valid = 1'b1; opsel = op; A = a; B = b;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "/in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; A = $urandom; B = $urandom; opsel = 4'($urandom);
    lat = 0; early = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!out_valid && in_ready) early++;
    end while (!out_valid && lat < 64);
    chk({tag, "/latency"}, 64'(lat), (op == 4'd7) ? 64'd32 : 64'd1);
    chk({tag, "/busy_ready"}, 64'(early), 64'd0);
    chk({tag, "/result"}, 64'(obs_pack()), 64'(model(op, a, b)));
  endtask

  initial begin
    logic [3:0]  sop;
    logic [31:0] sa, sb;
    logic [35:0] exp_prev, exp_bp;
    int          seen;

    // Reset state, held and just after release.
    repeat (3) @(negedge clk);
    chk("rst/out_valid", 64'(out_valid), 64'd0);
    chk("rst/result", 64'(obs_pack()), 64'd0);
    chk("rst/in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    #1;
    chk("rel/in_ready", 64'(in_ready), 64'd1);
    chk("rel/out_valid", 64'(out_valid), 64'd0);

    issue(4'd5, 32'hFFFF_FFFF, 32'd1, "add_wrap");
    issue(4'd6, 32'h8000_0000, 32'd1, "sub_ovf");
    issue(4'd6, 32'd1, 32'd2, "sub_borrow");
    issue(4'd7, 32'h0001_0000, 32'h0001_0000, "mul_hi");
    issue(4'd7, 32'd7, 32'd6, "mul_small");
    issue(4'd10, 32'h8000_0000, 32'h24, "sra");
    issue(4'd8, 32'h8000_0001, 32'd1, "shl");
    issue(4'd8, 32'h8000_0001, 32'd32, "shl_zero");
    issue(4'd9, 32'h0000_0003, 32'd1, "shr");
    issue(4'd0, 32'h1234_5678, 32'h9ABC_DEF0, "none");
    issue(4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "undef");
    issue(4'd4, 32'h0F0F_0000, 32'd0, "neg");
    issue(4'd5, 32'h7FFF_FFFF, 32'd1, "add_ovf");

    for (int i = 0; i < 60; i++) begin
      sop = 4'($urandom_range(0, 15));
      sa  = $urandom;
      sb  = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      issue(sop, sa, sb, "rnd");
    end

    // Back-to-back stream of single-cycle ops with out_ready held high.
    out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        chk("stream/out_valid", 64'(out_valid), 64'd1);
        chk("stream/result", 64'(obs_pack()), 64'(exp_prev));
      end
      do sop = 4'($urandom_range(1, 10)); while (sop == 4'd7);
      sa = $urandom; sb = $urandom;
      in_valid = 1'b1; opsel = sop; A = sa; B = sb;
      chk("stream/in_ready", 64'(in_ready), 64'd1);
      exp_prev = model(sop, sa, sb);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("stream/last", 64'(obs_pack()), 64'(exp_prev));
    @(negedge clk);
    chk("stream/drain", 64'(out_valid), 64'd0);

    // Backpressure: result held while out_ready is low, then overlap transfer.
    out_ready = 1'b0;
    sa = $urandom; sb = $urandom;
    in_valid = 1'b1; opsel = 4'd5; A = sa; B = sb;
    exp_bp = model(4'd5, sa, sb);
    @(posedge clk);
    #1;
    in_valid = 1'b0; A = $urandom; B = $urandom;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp/out_valid", 64'(out_valid), 64'd1);
      chk("bp/in_ready", 64'(in_ready), 64'd0);
      chk("bp/hold", 64'(obs_pack()), 64'(exp_bp));
    end
    sa = $urandom; sb = $urandom;
    out_ready = 1'b1;
    in_valid = 1'b1; opsel = 4'd6; A = sa; B = sb;
    #1;
    chk("bp/release_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp/no_bubble", 64'(out_valid), 64'd1);
    chk("bp/next", 64'(obs_pack()), 64'(model(4'd6, sa, sb)));
    @(negedge clk);
    chk("bp/fall", 64'(out_valid), 64'd0);

    // Reset in the middle of a multiply.
    in_valid = 1'b1; opsel = 4'd7; A = $urandom; B = $urandom;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rmul/out_valid", 64'(out_valid), 64'd0);
    chk("rmul/result", 64'(obs_pack()), 64'd0);
    chk("rmul/in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rmul/rel_ready", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rmul/no_output", 64'(seen), 64'd0);
    issue(4'd5, 32'd2, 32'd3, "post_rst_add");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
